pad_pwr_domain_sequencer: RTL and testbench

//  Sequences enables for N_DOM chip_io power/clamp domains (VDDA/VSSA-class LVC pad groups) in ascending

---
 rtl/pad_pwr_domain_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pad_pwr_domain_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_pwr_domain_sequencer.sv
// ---------------------------------------------------------------------------
// pad_pwr_domain_sequencer
//   Brings N_DOM pad-ring power/clamp domains up in ascending order and down
//   in descending order. Each power-up step raises one enable, lets the rail
//   settle for SETTLE cycles, then waits up to TIMEOUT cycles for that
//   domain's synchronised power-good. Once every domain is up, the block
//   keeps watching power-good and drops all enables at once if any is lost.
//
// Ports
//   clk         single clock
//   resetb      asynchronous active-low reset
//   start       begin power-up (only acted on in IDLE)
//   shutdown    begin ordered power-down (acted on in RAMP and UP)
//   clr_fault   leave FAULT and return to IDLE
//   pgood       per-domain power-good, asynchronous to clk
//   en          per-domain enable, always thermometer coded
//   all_up      high while every domain is up
//   busy        high while ramping up or powering down
//   fault       high while latched in FAULT
//   fault_idx   domain that caused the fault
//   fault_code  0 none, 1 power-good timeout, 2 power-good lost while up
// ---------------------------------------------------------------------------
module pad_pwr_domain_sequencer #(
  parameter int N_DOM   = 4,
  parameter int CNT_W   = 12,
  parameter int SETTLE  = 100,
  parameter int TIMEOUT = 1000,
  parameter int OFF_DLY = 50
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             shutdown,
  input  logic             clr_fault,
  input  logic [N_DOM-1:0] pgood,
  output logic [N_DOM-1:0] en,
  output logic             all_up,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       fault_idx,
  output logic [1:0]       fault_code
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_DLY - 1);
  localparam logic [2:0]       LAST_IDX     = 3'(N_DOM - 1);

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_UP, S_DOWN, S_FAULT} state_t;

  state_t             state, state_nxt;
  logic               wait_ph, wait_ph_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_DOM-1:0]   en_nxt;
  logic [2:0]         fault_idx_nxt;
  logic [1:0]         fault_code_nxt;
  logic               all_up_nxt, busy_nxt, fault_nxt;
  logic [N_DOM-1:0]   pg_meta, pg_s;
  logic               pg_cur;
  logic               any_fail;
  logic [2:0]         low_fail;

  // Enable pattern with the lowest n domains on.
  function automatic logic [N_DOM-1:0] therm(input logic [3:0] n);
    logic [N_DOM-1:0] t;
    for (int i = 0; i < N_DOM; i++) t[i] = (4'(i) < n);
    return t;
  endfunction

  // Two-flop synchroniser; cleared by reset so no stale power-good survives.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pg_meta <= '0;
      pg_s    <= '0;
    end else begin
      pg_meta <= pgood;
      pg_s    <= pg_meta;
    end
  end

  // Power-good of the domain currently being ramped, plus the lowest failing
  // domain for the loss-while-up fault report.
  always_comb begin
    pg_cur   = 1'b0;
    any_fail = 1'b0;
    low_fail = 3'd0;
    for (int i = 0; i < N_DOM; i++) begin
      if (idx == 3'(i)) pg_cur = pg_s[i];
    end
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (!pg_s[i]) begin
        any_fail = 1'b1;
        low_fail = 3'(i);
      end
    end
  end

  // State and output registers. Every output is a flop so nothing passes
  // combinationally from an input pin to an output pin.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= S_IDLE;
      wait_ph    <= 1'b0;
      idx        <= 3'd0;
      cnt        <= '0;
      en         <= '0;
      fault_idx  <= 3'd0;
      fault_code <= 2'd0;
      all_up     <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_ph    <= wait_ph_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      en         <= en_nxt;
      fault_idx  <= fault_idx_nxt;
      fault_code <= fault_code_nxt;
      all_up     <= all_up_nxt;
      busy       <= busy_nxt;
      fault      <= fault_nxt;
    end
  end

  // Next-state logic. In RAMP, shutdown outranks both a power-good step and
  // a timeout; in UP, a power-good loss outranks shutdown. Entering DOWN
  // clears the highest enabled domain straight away, and each later drop
  // follows OFF_DLY cycles after the previous one.
  always_comb begin
    state_nxt      = state;
    wait_ph_nxt    = wait_ph;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    en_nxt         = en;
    fault_idx_nxt  = fault_idx;
    fault_code_nxt = fault_code;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_RAMP;
          idx_nxt     = 3'd0;
          cnt_nxt     = '0;
          wait_ph_nxt = 1'b0;
          en_nxt      = therm(4'd1);
        end
      end
      S_RAMP: begin
        if (shutdown) begin
          state_nxt = S_DOWN;
          cnt_nxt   = '0;
          en_nxt    = therm({1'b0, idx});
        end else if (!wait_ph) begin
          if (cnt == SETTLE_LAST) begin
            wait_ph_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (pg_cur) begin
          cnt_nxt = '0;
          if (idx == LAST_IDX) begin
            state_nxt = S_UP;
          end else begin
            idx_nxt     = idx + 3'd1;
            wait_ph_nxt = 1'b0;
            en_nxt      = therm({1'b0, idx} + 4'd2);
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt      = S_FAULT;
          en_nxt         = '0;
          fault_idx_nxt  = idx;
          fault_code_nxt = 2'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_UP: begin
        if (any_fail) begin
          state_nxt      = S_FAULT;
          en_nxt         = '0;
          fault_idx_nxt  = low_fail;
          fault_code_nxt = 2'd2;
        end else if (shutdown) begin
          state_nxt = S_DOWN;
          idx_nxt   = LAST_IDX;
          cnt_nxt   = '0;
          en_nxt    = therm({1'b0, LAST_IDX});
        end
      end
      S_DOWN: begin
        if (cnt == OFF_LAST) begin
          cnt_nxt = '0;
          if (idx == 3'd0) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt = idx - 3'd1;
            en_nxt  = therm({1'b0, idx} - 4'd1);
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_FAULT: begin
        en_nxt = '0;
        if (clr_fault) begin
          state_nxt      = S_IDLE;
          fault_idx_nxt  = 3'd0;
          fault_code_nxt = 2'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        en_nxt    = '0;
      end
    endcase
  end

  // Status flags follow the state being entered so they line up with en.
  always_comb begin
    all_up_nxt = (state_nxt == S_UP);
    busy_nxt   = (state_nxt == S_RAMP) || (state_nxt == S_DOWN);
    fault_nxt  = (state_nxt == S_FAULT);
  end

endmodule

// File: tb/tb_pad_pwr_domain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pad_pwr_domain_sequencer
//   Drives power-up scenarios described by per-domain power-good delays and
//   an optional shutdown or power-good drop, and compares the sequencer's
//   outputs every cycle against expectations built from event times.
// ---------------------------------------------------------------------------
module tb_pad_pwr_domain_sequencer;

  localparam int N    = 4;
  localparam int S    = 4;
  localparam int T    = 8;
  localparam int OFF  = 3;
  localparam int MAXK = 256;

  logic       clk = 1'b0;
  logic       resetb, start, shutdown, clr_fault;
  logic [3:0] pgood, en;
  logic       all_up, busy, fault;
  logic [2:0] fault_idx;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  pad_pwr_domain_sequencer #(
    .N_DOM(N), .CNT_W(8), .SETTLE(S), .TIMEOUT(T), .OFF_DLY(OFF)
  ) dut (
    .clk(clk), .resetb(resetb), .start(start), .shutdown(shutdown),
    .clr_fault(clr_fault), .pgood(pgood), .en(en), .all_up(all_up),
    .busy(busy), .fault(fault), .fault_idx(fault_idx), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // d holds one hex digit per domain: cycles after that domain's enable
  // before its power-good rises; 15 means it never rises.
  typedef struct {
    logic [15:0] d;
    bit          sd;
    int          q;
    logic [3:0]  drop;
    int          r;
    bit          exp_up;
    logic [1:0]  exp_code;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[8];

  // Expected outputs after each edge k of a scenario (edge 0 takes start).
  logic [3:0] m_en[MAXK];
  bit         m_up[MAXK], m_busy[MAXK], m_fault[MAXK];
  logic [2:0] m_fidx[MAXK];
  logic [1:0] m_fcode[MAXK];
  int         pg_on[N];
  bit         sd_eff, drop_eff;
  int         q_eff, clr_k, drop_k, end_k;
  logic [3:0] drop_m;

  function automatic logic [3:0] ones(input int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Domain i's step resolves at E[i] + max(SETTLE+1, d+3); the +3 is the
  // drive-to-edge delay plus the two synchroniser flops. If that lands after
  // E[i]+SETTLE+TIMEOUT the domain times out there instead.
  task automatic build_model(input logic [15:0] d, input bit sd, input int q,
                             input logic [3:0] drop, input int r);
    int E[N];
    int rises, outc, fi, h, di, step, cnt, j, low;
    bit is_up;
    rises = 1; outc = 0; fi = 0; is_up = 0; h = 0; low = 0;
    for (int i = 0; i < N; i++) E[i] = 0;
    for (int i = 0; i < N; i++) begin
      di = int'(d[i*4 +: 4]);
      if (di == 15 || di + 3 > S + T) begin
        outc = E[i] + S + T;
        fi = i;
        break;
      end
      step = (di + 3 > S + 1) ? di + 3 : S + 1;
      if (i == N - 1) begin
        outc = E[i] + step;
        is_up = 1;
      end else begin
        E[i+1] = E[i] + step;
        rises++;
      end
    end
    for (int i = 0; i < N; i++) begin
      di = int'(d[i*4 +: 4]);
      pg_on[i] = (i < rises && di != 15) ? E[i] + di + 1 : -1;
    end
    sd_eff = sd && q >= 1 && (q <= outc || is_up);
    q_eff = q;
    if (sd_eff) begin
      if (q <= outc) begin
        h = -1;
        for (int i = 0; i < rises; i++) if (E[i] < q) h++;
      end else begin
        h = N - 1;
      end
    end
    drop_m = drop;
    drop_eff = is_up && !sd_eff && drop != 4'd0;
    drop_k = outc + r;
    for (int i = N - 1; i >= 0; i--) if (drop[i]) low = i;
    clr_k = -1;
    if (!sd_eff && !is_up) clr_k = outc + 3;
    if (drop_eff) clr_k = drop_k + 6;
    if (sd_eff) end_k = q + (h + 1) * OFF + 2;
    else if (drop_eff) end_k = drop_k + 8;
    else end_k = outc + 5;
    for (int k = 0; k < MAXK; k++) begin
      cnt = 0;
      for (int i = 0; i < rises; i++) if (E[i] <= k) cnt++;
      m_en[k] = ones(cnt); m_up[k] = 0; m_busy[k] = 1; m_fault[k] = 0;
      m_fidx[k] = 3'd0; m_fcode[k] = 2'd0;
      if (sd_eff && k >= q) begin
        j = (k - q) / OFF;
        m_en[k] = (j <= h) ? ones(h - j) : 4'd0;
        m_busy[k] = (j <= h);
      end else if (!is_up && k >= outc) begin
        m_en[k] = 4'd0; m_busy[k] = 0;
        if (k < outc + 3) begin
          m_fault[k] = 1; m_fidx[k] = 3'(fi); m_fcode[k] = 2'd1;
        end
      end else if (is_up && k >= outc) begin
        m_en[k] = 4'hF; m_up[k] = 1; m_busy[k] = 0;
        if (drop_eff && k >= drop_k + 3) begin
          m_en[k] = 4'd0; m_up[k] = 0;
          if (k < drop_k + 6) begin
            m_fault[k] = 1; m_fidx[k] = 3'(low); m_fcode[k] = 2'd2;
          end
        end
      end
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [15:0] d, input bit sd,
                                input int q, input logic [3:0] drop, input int r,
                                output bit seen_up, output logic [1:0] oc,
                                output logic [2:0] oi);
    build_model(d, sd, q, drop, r);
    seen_up = 0; oc = 2'd0; oi = 3'd0;
    for (int k = 0; k <= end_k && k < MAXK; k++) begin
      start     = (k == 0);
      shutdown  = sd_eff && (k == q_eff);
      clr_fault = (k == clr_k);
      for (int i = 0; i < N; i++)
        pgood[i] = (pg_on[i] >= 0 && k >= pg_on[i]) &&
                   !(drop_eff && k >= drop_k + 1 && drop_m[i]);
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("%s cycle %0d {en,up,busy,fault,idx,code}", tag, k),
                   {en, all_up, busy, fault, fault_idx, fault_code},
                   {m_en[k], m_up[k], m_busy[k], m_fault[k], m_fidx[k], m_fcode[k]});
      if (all_up) seen_up = 1;
      if (fault) begin
        oc = fault_code;
        oi = fault_idx;
      end
    end
    start = 0; shutdown = 0; clr_fault = 0; pgood = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
    check(name, 32'(act), 32'(exp));
  endtask

  bit         s_up;
  logic [1:0] s_code;
  logic [2:0] s_idx;

  initial begin
    vecs[0] = '{16'h0000, 1'b0, 0,  4'b1010, 2, 1'b1, 2'd2, 3'd1};
    vecs[1] = '{16'h0F00, 1'b0, 0,  4'b0000, 1, 1'b0, 2'd1, 3'd2};
    vecs[2] = '{16'h0000, 1'b1, 25, 4'b0000, 1, 1'b1, 2'd0, 3'd0};
    vecs[3] = '{16'h0040, 1'b1, 12, 4'b0000, 1, 1'b0, 2'd0, 3'd0};
    vecs[4] = '{16'h1973, 1'b0, 0,  4'b0001, 3, 1'b1, 2'd2, 3'd0};
    vecs[5] = '{16'h00A0, 1'b0, 0,  4'b0000, 1, 1'b0, 2'd1, 3'd1};
    vecs[6] = '{16'h0000, 1'b0, 0,  4'b1000, 1, 1'b1, 2'd2, 3'd3};
    vecs[7] = '{16'h0000, 1'b1, 1,  4'b0000, 1, 1'b0, 2'd0, 3'd0};

    resetb = 1'b0; start = 0; shutdown = 0; clr_fault = 0; pgood = 4'd0;
    #12;
    check("reset outputs", 32'({en, all_up, busy, fault, fault_idx, fault_code}), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("idle after reset", 32'({en, all_up, busy, fault, fault_code}), 32'd0);

    for (int v = 0; v < 8; v++) begin
      apply_stimulus($sformatf("vec%0d", v), vecs[v].d, vecs[v].sd, vecs[v].q,
                     vecs[v].drop, vecs[v].r, s_up, s_code, s_idx);
      check($sformatf("vec%0d reached up", v), 32'(s_up), 32'(vecs[v].exp_up));
      check($sformatf("vec%0d fault_code", v), 32'(s_code), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d fault_idx", v), 32'(s_idx), 32'(vecs[v].exp_idx));
    end

    for (int t = 0; t < 30; t++) begin
      logic [15:0] rd;
      for (int i = 0; i < N; i++) rd[i*4 +: 4] = 4'($urandom_range(0, 12));
      apply_stimulus($sformatf("rnd%0d", t), rd, 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 45)), 4'($urandom_range(1, 15)),
                     int'($urandom_range(1, 5)), s_up, s_code, s_idx);
    end

    // Asynchronous reset in the middle of a ramp.
    pgood = 4'hF; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    check("ramp before reset en", 32'(en), 32'(4'b0011));
    #2 resetb = 1'b0;
    #1 check("async reset in RAMP", 32'({en, all_up, busy, fault, fault_code}), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    pgood = 4'd0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while latched in FAULT.
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 40 && !fault; c++) @(negedge clk);
    check("timeout fault reached", 32'({fault, fault_code, fault_idx}), 32'({1'b1, 2'd1, 3'd0}));
    #2 resetb = 1'b0;
    #1 check("async reset in FAULT", 32'({en, all_up, busy, fault, fault_idx, fault_code}), 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
